// File: rtl/covariance_pkg.sv
// Shared types, default sizes and slice helpers for the covariance accumulator.
package covariance_pkg;

  localparam int unsigned NChDefault     = 4;
  localparam int unsigned SampleWDefault = 16;
  localparam int unsigned AccWDefault    = 32;

  // Input-side FSM: accumulate beats, drain the MAC pipeline, wait for a free output bank.
  typedef enum logic [1:0] {
    StAccum = 2'd0,
    StFlush = 2'd1,
    StHold  = 2'd2
  } in_state_e;

  // LSB of the real half of channel k in s_axis_tdata (sample width w).
  function automatic int unsigned re_lsb(int unsigned k, int unsigned w);
    return 2 * k * w;
  endfunction

  // LSB of the imaginary half of channel k in s_axis_tdata (sample width w).
  function automatic int unsigned im_lsb(int unsigned k, int unsigned w);
    return 2 * k * w + w;
  endfunction

  // Packed index of upper-triangle element (i, j), i <= j, in an n x n matrix.
  function automatic int unsigned tri_idx(int unsigned i, int unsigned j, int unsigned n);
    return (i * (2 * n - i + 1)) / 2 + (j - i);
  endfunction

endpackage

// File: rtl/cmac_sat.sv
// Complex multiply-conjugate-accumulate: acc += a * conj(b), with signed saturation.
// Two stages: full-precision product register, then saturating accumulate register.
module cmac_sat #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned ACC_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clken,
  input  logic                       valid,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] a_re,
  input  logic signed [SAMPLE_W-1:0] a_im,
  input  logic signed [SAMPLE_W-1:0] b_re,
  input  logic signed [SAMPLE_W-1:0] b_im,
  output logic signed [ACC_W-1:0]    acc_re,
  output logic signed [ACC_W-1:0]    acc_im,
  output logic                       ovf
);

  localparam int unsigned MUL_W  = 2 * SAMPLE_W;
  localparam int unsigned PROD_W = 2 * SAMPLE_W + 1;
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  // Operands widened first so each product is exact in MUL_W bits.
  logic signed [MUL_W-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [MUL_W-1:0] rr, ii, ir, ri;
  logic signed [PROD_W-1:0] p_re_d, p_im_d, p_re_q, p_im_q;
  logic                     p_vld_q;
  logic signed [ACC_W-1:0]  acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic                     ovf_q, sat_d;
  logic signed [ACC_W:0]    sum_re, sum_im;

  assign a_re_x = {{SAMPLE_W{a_re[SAMPLE_W-1]}}, a_re};
  assign a_im_x = {{SAMPLE_W{a_im[SAMPLE_W-1]}}, a_im};
  assign b_re_x = {{SAMPLE_W{b_re[SAMPLE_W-1]}}, b_re};
  assign b_im_x = {{SAMPLE_W{b_im[SAMPLE_W-1]}}, b_im};

  assign rr = a_re_x * b_re_x;
  assign ii = a_im_x * b_im_x;
  assign ir = a_im_x * b_re_x;
  assign ri = a_re_x * b_im_x;

  // (ar + j ai)(br - j bi) = (ar br + ai bi) + j (ai br - ar bi)
  assign p_re_d = {rr[MUL_W-1], rr} + {ii[MUL_W-1], ii};
  assign p_im_d = {ir[MUL_W-1], ir} - {ri[MUL_W-1], ri};

  // Saturating add of the registered product into the accumulator.
  always_comb begin
    sum_re   = {acc_re_q[ACC_W-1], acc_re_q} + (ACC_W+1)'(p_re_q);
    sum_im   = {acc_im_q[ACC_W-1], acc_im_q} + (ACC_W+1)'(p_im_q);
    acc_re_d = sum_re[ACC_W-1:0];
    acc_im_d = sum_im[ACC_W-1:0];
    sat_d    = 1'b0;
    if (sum_re[ACC_W] != sum_re[ACC_W-1]) begin
      acc_re_d = sum_re[ACC_W] ? AccMin : AccMax;
      sat_d    = 1'b1;
    end
    if (sum_im[ACC_W] != sum_im[ACC_W-1]) begin
      acc_im_d = sum_im[ACC_W] ? AccMin : AccMax;
      sat_d    = 1'b1;
    end
  end

  // Product and accumulate stages; clear empties both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_vld_q  <= 1'b0;
      p_re_q   <= '0;
      p_im_q   <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      ovf_q    <= 1'b0;
    end else if (clken) begin
      if (clear) begin
        p_vld_q  <= 1'b0;
        p_re_q   <= '0;
        p_im_q   <= '0;
        acc_re_q <= '0;
        acc_im_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        p_vld_q <= valid;
        if (valid) begin
          p_re_q <= p_re_d;
          p_im_q <= p_im_d;
        end
        if (p_vld_q) begin
          acc_re_q <= acc_re_d;
          acc_im_q <= acc_im_d;
          ovf_q    <= ovf_q | sat_d;
        end
      end
    end
  end

  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/covariance_accumulator.sv
// Streaming spatial covariance R = sum x x^H over a snapshot; drains the full
// N_CH x N_CH matrix row-major from a single output bank.
module covariance_accumulator
  import covariance_pkg::*;
#(
  parameter int unsigned N_CH     = NChDefault,
  parameter int unsigned SAMPLE_W = SampleWDefault,
  parameter int unsigned ACC_W    = AccWDefault
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clken,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [N_CH*2*SAMPLE_W-1:0]    s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [2*ACC_W-1:0]            m_axis_tdata,
  output logic [2*$clog2(N_CH)-1:0]     m_axis_tuser,
  output logic                          overflow
);

  localparam int unsigned NT    = N_CH * (N_CH + 1) / 2;
  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_CH - 1);
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [SAMPLE_W-1:0] x_re [N_CH];
  logic signed [SAMPLE_W-1:0] x_im [N_CH];
  logic signed [ACC_W-1:0]    acc_re [NT];
  logic signed [ACC_W-1:0]    acc_im [NT];
  logic [NT-1:0]              acc_ovf;
  logic signed [ACC_W-1:0]    bank_re_q [NT];
  logic signed [ACC_W-1:0]    bank_im_q [NT];
  logic signed [ACC_W-1:0]    full_re [N_CH][N_CH];
  logic signed [ACC_W-1:0]    full_im [N_CH][N_CH];

  in_state_e        state_q;
  logic             flush_q;
  logic             bank_full_q;
  logic             ovf_q;
  logic [IDX_W-1:0] row_q, col_q;
  logic             s_fire, m_fire, bank_last, bank_free, copy;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign x_re[k] = s_axis_tdata[re_lsb(k, SAMPLE_W) +: SAMPLE_W];
    assign x_im[k] = s_axis_tdata[im_lsb(k, SAMPLE_W) +: SAMPLE_W];
  end

  // Reset gates ready combinationally so it drops the moment reset asserts.
  assign s_axis_tready = reset_n & clken & (state_q == StAccum);
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign m_fire        = bank_full_q & m_axis_tready & clken;
  assign bank_last     = (row_q == LastIdx) && (col_q == LastIdx);
  // The bank is reusable in the same cycle its final beat transfers.
  assign bank_free     = !bank_full_q || (m_fire && bank_last);
  assign copy          = clken && bank_free &&
                         (((state_q == StFlush) && flush_q) || (state_q == StHold));

  // Upper-triangle MAC array; lower triangle is reconstructed on output.
  for (genvar i = 0; i < N_CH; i++) begin : g_mac_row
    for (genvar j = i; j < N_CH; j++) begin : g_mac_col
      localparam int unsigned E = tri_idx(i, j, N_CH);
      cmac_sat #(
        .SAMPLE_W(SAMPLE_W),
        .ACC_W   (ACC_W)
      ) u_cmac (
        .clk    (clk),
        .reset_n(reset_n),
        .clken  (clken),
        .valid  (s_fire),
        .clear  (copy),
        .a_re   (x_re[i]),
        .a_im   (x_im[i]),
        .b_re   (x_re[j]),
        .b_im   (x_im[j]),
        .acc_re (acc_re[E]),
        .acc_im (acc_im[E]),
        .ovf    (acc_ovf[E])
      );
    end
  end

  // Full-matrix view of the bank: diagonal imag forced to zero, lower = conj(upper).
  for (genvar i = 0; i < N_CH; i++) begin : g_view_row
    for (genvar j = 0; j < N_CH; j++) begin : g_view_col
      if (i <= j) begin : g_upper
        localparam int unsigned E = tri_idx(i, j, N_CH);
        assign full_re[i][j] = bank_re_q[E];
        assign full_im[i][j] = (i == j) ? '0 : bank_im_q[E];
      end else begin : g_lower
        localparam int unsigned E = tri_idx(j, i, N_CH);
        assign full_re[i][j] = bank_re_q[E];
        // Negating the most negative value would wrap; clamp it instead.
        assign full_im[i][j] = (bank_im_q[E] == AccMin) ? AccMax : -bank_im_q[E];
      end
    end
  end

  // Input FSM: two flush cycles let the last beat clear both MAC stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAccum;
      flush_q <= 1'b0;
    end else if (clken) begin
      unique case (state_q)
        StAccum: begin
          flush_q <= 1'b0;
          if (s_fire && s_axis_tlast) state_q <= StFlush;
        end
        StFlush: begin
          if (flush_q) begin
            flush_q <= 1'b0;
            state_q <= bank_free ? StAccum : StHold;
          end else begin
            flush_q <= 1'b1;
          end
        end
        StHold: begin
          if (bank_free) state_q <= StAccum;
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  // Output bank: load on copy, walk row-major on each accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_re_q   <= '{default: '0};
      bank_im_q   <= '{default: '0};
      bank_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
    end else if (clken) begin
      if (copy) begin
        bank_re_q   <= acc_re;
        bank_im_q   <= acc_im;
        bank_full_q <= 1'b1;
        ovf_q       <= |acc_ovf;
        row_q       <= '0;
        col_q       <= '0;
      end else if (m_fire) begin
        if (bank_last) begin
          bank_full_q <= 1'b0;
        end else if (col_q == LastIdx) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign m_axis_tvalid = bank_full_q;
  assign m_axis_tlast  = bank_full_q & bank_last;
  assign m_axis_tdata  = {full_im[row_q][col_q], full_re[row_q][col_q]};
  assign m_axis_tuser  = {row_q, col_q};
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_covariance_accumulator.sv
// Self-checking bench for covariance_accumulator with a scoreboard of expected output beats.
module tb_covariance_accumulator;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int AW = 32;
  localparam longint AccMax = 64'sd2147483647;
  localparam longint AccMin = -64'sd2147483648;

  logic              clk, reset_n, clken;
  logic              s_tvalid, s_tready, s_tlast;
  logic [N*2*SW-1:0] s_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [2*AW-1:0]   m_tdata;
  logic [3:0]        m_tuser;
  logic              overflow;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t   sb[$];
  exp_t   exp_beat;
  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_re[N][N];
  longint m_im[N][N];
  bit     m_ovf;
  int     xr[N];
  int     xi[N];
  bit     toggle_en = 0;
  logic [63:0] held_data;
  logic [3:0]  held_user;
  bit          held = 0;

  covariance_accumulator #(
    .N_CH    (N),
    .SAMPLE_W(SW),
    .ACC_W   (AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken        (clken),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tdata (s_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tuser (m_tuser),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock enable: steady high, or toggling every cycle when requested.
  initial begin
    clken = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clken = toggle_en ? ~clken : 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, inout bit flag);
    if (v > AccMax) begin flag = 1'b1; return AccMax; end
    if (v < AccMin) begin flag = 1'b1; return AccMin; end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m_re[i][j] = 0;
        m_im[i][j] = 0;
      end
    m_ovf = 1'b0;
  endtask

  // Every element computed directly as x_i * conj(x_j).
  task automatic model_add();
    longint pr, pi;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pr = longint'(xr[i]) * xr[j] + longint'(xi[i]) * xi[j];
        pi = longint'(xi[i]) * xr[j] - longint'(xr[i]) * xi[j];
        m_re[i][j] = sat(m_re[i][j] + pr, m_ovf);
        m_im[i][j] = sat(m_im[i][j] + pi, m_ovf);
      end
  endtask

  task automatic model_push();
    exp_t e;
    longint r, q;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r      = m_re[i][j];
        q      = m_im[i][j];
        e.data = {q[31:0], r[31:0]};
        e.user = 4'(i * N + j);
        e.last = (i == N - 1) && (j == N - 1);
        e.ovf  = m_ovf;
        sb.push_back(e);
      end
  endtask

  // 0: all 1+j0, 1: ch0=j1 ch1=1, 2: all 0x7FFF, 3: random, 4: ch0=3+j4
  task automatic set_pattern(input int mode);
    for (int k = 0; k < N; k++) begin
      xr[k] = 0;
      xi[k] = 0;
      case (mode)
        0: xr[k] = 1;
        1: begin if (k == 0) xi[k] = 1; if (k == 1) xr[k] = 1; end
        2: xr[k] = 32767;
        3: begin
          xr[k] = int'($urandom_range(2000)) - 1000;
          xi[k] = int'($urandom_range(2000)) - 1000;
        end
        4: if (k == 0) begin xr[k] = 3; xi[k] = 4; end
        default: ;
      endcase
    end
  endtask

  task automatic send_beat(input bit last);
    bit done = 1'b0;
    int guard = 0;
    logic [31:0] r, q;
    for (int k = 0; k < N; k++) begin
      r = xr[k];
      q = xi[k];
      s_tdata[k*2*SW +: SW]      = r[SW-1:0];
      s_tdata[k*2*SW + SW +: SW] = q[SW-1:0];
    end
    s_tvalid = 1'b1;
    s_tlast  = last;
    while (!done) begin
      @(negedge clk);
      if (s_tready) done = 1'b1;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 500) begin
        check_val("s_accept_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (done) begin
      model_add();
      if (last) begin
        model_push();
        model_clear();
      end
    end
  endtask

  task automatic send_snapshot(input int len, input int mode);
    for (int b = 0; b < len; b++) begin
      set_pattern(mode);
      send_beat(b == len - 1);
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || m_tvalid) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_val("drain_done", 64'(sb.size()), 0);
  endtask

  // Output monitor: sampled mid-cycle; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      held = 0;
    end else begin
      if (held) begin
        check_val("hold_tdata", m_tdata, held_data);
        check_val("hold_tuser", 64'(m_tuser), 64'(held_user));
      end
      held = 0;
      if (clken && m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_beat", 1, 0);
        end else begin
          exp_beat = sb.pop_front();
          check_val("tdata", m_tdata, exp_beat.data);
          check_val("tuser", 64'(m_tuser), 64'(exp_beat.user));
          check_val("tlast", 64'(m_tlast), 64'(exp_beat.last));
          check_val("overflow", 64'(overflow), 64'(exp_beat.ovf));
        end
      end else if (m_tvalid) begin
        held      = 1;
        held_data = m_tdata;
        held_user = m_tuser;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    model_clear();
    #3;
    check_val("rst_s_tready", 64'(s_tready), 0);
    check_val("rst_m_tvalid", 64'(m_tvalid), 0);
    check_val("rst_m_tlast", 64'(m_tlast), 0);
    check_val("rst_m_tdata", m_tdata, 0);
    check_val("rst_m_tuser", 64'(m_tuser), 0);
    check_val("rst_overflow", 64'(overflow), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("first_ready", 64'(s_tready), 1);
    @(posedge clk);
    #1;

    // All ones: every element 256+j0.
    send_snapshot(256, 0);
    wait_drain();

    // ch0 = j1, ch1 = 1: off-diagonal conjugate pair.
    send_snapshot(256, 1);
    wait_drain();

    // Saturation, then a clean snapshot must report no overflow.
    send_snapshot(3, 2);
    wait_drain();
    send_snapshot(1, 0);
    wait_drain();

    // Stalled drain while a second snapshot lands in HOLD.
    m_tready = 1'b0;
    send_snapshot(4, 3);
    repeat (5) begin @(posedge clk); #1; end
    check_val("stall_valid", 64'(m_tvalid), 1);
    send_snapshot(4, 3);
    repeat (30) begin @(posedge clk); #1; end
    check_val("hold_tready", 64'(s_tready), 0);
    check_val("hold_tuser0", 64'(m_tuser), 0);
    m_tready = 1'b1;
    guard = 0;
    while (!s_tready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_val("hold_release", 64'(s_tready), 1);
    check_val("hold_until_tlast", 64'(sb.size()), 16);
    wait_drain();

    // Reset mid-snapshot, then a fresh snapshot with no carry-over.
    for (int b = 0; b < 100; b++) begin
      set_pattern(0);
      send_beat(1'b0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst_s_tready", 64'(s_tready), 0);
    check_val("midrst_m_tvalid", 64'(m_tvalid), 0);
    model_clear();
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_snapshot(256, 0);
    wait_drain();

    // Single-beat snapshot, then the same with clken toggling.
    send_snapshot(1, 4);
    wait_drain();
    toggle_en = 1'b1;
    send_snapshot(1, 4);
    wait_drain();
    toggle_en = 1'b0;
    repeat (3) @(posedge clk);

    check_val("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
